// File: rtl/channel_scan_sequencer_pkg.sv
// Shared types and constants for the channel scan sequencer.
// Channel count and select width are fixed by the 3-to-8 decoder being driven.
package channel_scan_sequencer_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } scan_state_e;

endpackage

// File: rtl/channel_scan_sequencer_next_enabled_finder.sv
// Circular search for the next enabled channel strictly above the current index.
// The wrapped flag is set when the result is at or below the current index.
module next_enabled_finder
  import channel_scan_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  output logic [SEL_W-1:0]  next,
  output logic              wrapped
);

  logic [SEL_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest enabled channel wins.
  // Offset NUM_CH lands on cur itself, covering the single-channel case.
  always_comb begin
    next = cur;
    idx  = cur;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = cur + SEL_W'(i);
      if (mask[idx]) begin
        next = idx;
      end
    end
    wrapped = (next <= cur);
  end

endmodule

// File: rtl/channel_scan_sequencer.sv
// Steps a decoder select through the enabled channels, holding each for dwell+1
// cycles, in single-pass or continuous mode. All outputs are registered.
module channel_scan_sequencer
  import channel_scan_sequencer_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               one_shot,
  input  logic [NUM_CH-1:0]  en_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  scan_state_e        state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               sel_valid_q, sel_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               one_shot_q, one_shot_d;

  logic [NUM_CH-1:0]  find_mask;
  logic [SEL_W-1:0]   find_cur;
  logic [SEL_W-1:0]   find_next;
  logic               find_wrapped;

  // In idle, searching above the top index yields the lowest set bit of en_mask.
  assign find_mask = (state_q == StIdle) ? en_mask : mask_q;
  assign find_cur  = (state_q == StIdle) ? SEL_W'(NUM_CH - 1) : sel_q;

  next_enabled_finder u_finder (
    .mask    (find_mask),
    .cur     (find_cur),
    .next    (find_next),
    .wrapped (find_wrapped)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    sel_valid_d = sel_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wrap_d      = 1'b0;
    cnt_d       = cnt_q;
    mask_d      = mask_q;
    dwell_d     = dwell_q;
    one_shot_d  = one_shot_q;

    unique case (state_q)
      StIdle: begin
        if (start && !stop && (en_mask != '0)) begin
          state_d     = StScan;
          mask_d      = en_mask;
          dwell_d     = dwell;
          one_shot_d  = one_shot;
          sel_d       = find_next;
          sel_valid_d = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
        end
      end
      StScan: begin
        if (stop) begin
          state_d     = StIdle;
          sel_valid_d = 1'b0;
          busy_d      = 1'b0;
          cnt_d       = '0;
        end else if (cnt_q == dwell_q) begin
          cnt_d = '0;
          if (one_shot_q && find_wrapped) begin
            // Highest enabled channel has expired: end of the single pass.
            state_d     = StIdle;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            sel_d  = find_next;
            wrap_d = find_wrapped;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wrap_q      <= 1'b0;
      cnt_q       <= '0;
      mask_q      <= '0;
      dwell_q     <= '0;
      one_shot_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wrap_q      <= wrap_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      dwell_q     <= dwell_d;
      one_shot_q  <= one_shot_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Scoreboard bench: per-cycle expected outputs are queued when a scan is launched
// and compared one per clock, sampled 1 time unit after the rising edge.
module tb_channel_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       one_shot;
  logic [7:0] en_mask;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       done;
  logic       wrap;

  channel_scan_sequencer #(
    .DWELL_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .one_shot  (one_shot),
    .en_mask   (en_mask),
    .dwell     (dwell),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {sel_valid, busy, done, wrap, sel}.
  typedef logic [6:0] exp_t;
  exp_t       exp_q[$];
  logic [2:0] last_sel;
  int         n_checks;
  int         n_errors;
  bit         mon_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input bit v, input bit b, input bit dn, input bit w,
                          input logic [2:0] s);
    exp_q.push_back({v, b, dn, w, s});
  endtask

  // Expected trace of one scan: os=1 runs one pass then done, os=0 runs ncyc
  // scan cycles followed by the idle cycle after the bench's stop.
  task automatic push_scan(input logic [7:0] m, input int d, input bit os, input int ncyc);
    int chans[$];
    int k, hold, pass, n;
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    k = 0; hold = 0; pass = 0; n = 0;
    while (1) begin
      last_sel = 3'(chans[k]);
      push_exp(1'b1, 1'b1, 1'b0, (hold == 0 && k == 0 && pass > 0), last_sel);
      n++;
      if (hold == d) begin
        hold = 0;
        if (k == chans.size() - 1) begin
          k = 0;
          pass++;
          if (os) break;
        end else begin
          k++;
        end
      end else begin
        hold++;
      end
      if (!os && n == ncyc) break;
    end
    if (os) begin
      push_exp(1'b0, 1'b0, 1'b1, 1'b0, last_sel);
      push_exp(1'b0, 1'b0, 1'b0, 1'b0, last_sel);
    end else begin
      push_exp(1'b0, 1'b0, 1'b0, 1'b0, last_sel);
    end
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 300;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_oneshot(input logic [7:0] m, input int d, input string tag);
    @(negedge clk);
    en_mask = m; dwell = 8'(d); one_shot = 1'b1; start = 1'b1;
    push_scan(m, d, 1'b1, 0);
    @(negedge clk);
    start = 1'b0;
    wait_drain(tag);
  endtask

  // Continuous scan stopped so that stop is sampled on the edge after ncyc scan cycles.
  task automatic run_cont(input logic [7:0] m, input int d, input int ncyc,
                          input bit disturb, input string tag);
    @(negedge clk);
    en_mask = m; dwell = 8'(d); one_shot = 1'b0; start = 1'b1;
    push_scan(m, d, 1'b0, ncyc);
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      en_mask = 8'hFF; dwell = 8'd0; one_shot = 1'b1;
    end
    for (int i = 0; i < ncyc - 1; i++) begin
      @(negedge clk);
      if (disturb) start = (i == 1);
    end
    start = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_drain(tag);
  endtask

  task automatic run_idle(input logic [7:0] m, input bit stp, input string tag);
    @(negedge clk);
    en_mask = m; dwell = 8'd0; one_shot = 1'b0; start = 1'b1; stop = stp;
    for (int i = 0; i < 3; i++) push_exp(1'b0, 1'b0, 1'b0, 1'b0, last_sel);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    wait_drain(tag);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out{v,b,d,w,sel}", {25'd0, sel_valid, busy, done, wrap, sel}, {25'd0, e});
    end
  end

  initial begin
    n_checks = 0; n_errors = 0; mon_en = 1'b1; last_sel = 3'd0;
    start = 1'b0; stop = 1'b0; one_shot = 1'b0; en_mask = 8'h00; dwell = 8'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", {sel_valid, busy, done, wrap, sel}, 7'd0);

    // Start is already high when reset releases; the first edge must take it.
    @(negedge clk);
    rst_n = 1'b1;
    en_mask = 8'b1010_0101; dwell = 8'd0; one_shot = 1'b1; start = 1'b1;
    push_scan(8'b1010_0101, 0, 1'b1, 0);
    @(negedge clk);
    start = 1'b0;
    wait_drain("oneshot_a5");

    run_cont(8'b1000_0001, 2, 14, 1'b0, "cont_81_dwell2");
    run_cont(8'b0001_0000, 1, 7, 1'b0, "cont_single_ch4");
    run_idle(8'h00, 1'b0, "start_empty_mask");
    run_cont(8'b0010_0110, 1, 9, 1'b1, "cont_26_disturbed");
    run_idle(8'hFF, 1'b1, "start_with_stop");
    run_oneshot(8'b0000_1000, 3, "oneshot_single_ch3");
    run_oneshot(8'b1000_0000, 0, "oneshot_ch7");

    // Reset in the middle of a dwell, then confirm a quiet idle afterwards.
    @(negedge clk);
    en_mask = 8'h0F; dwell = 8'd5; one_shot = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("busy_before_reset", {sel_valid, busy}, 2'b11);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1 check("midscan_reset_outputs", {sel_valid, busy, done, wrap, sel}, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_sel = 3'd0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_exp(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    mon_en = 1'b1;
    wait_drain("after_reset_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/channel_scan_sequencer.md
CHANNEL_SCAN_SEQUENCER -- requirements
Module: channel_scan_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 8, giving the dwell-count width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a scan, sampled in IDLE only.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the scan.
REQ-007 The block SHALL have port one_shot, input, 1 bit: 1 = single pass, 0 = continuous.
REQ-008 The block SHALL have port en_mask, input, 8 bits: channel enable, bit i = channel i.
REQ-009 The block SHALL have port dwell, input, DWELL_W bits: extra hold cycles per channel.
REQ-010 The block SHALL have port sel, output, 3 bits: binary channel index feeding the 3-to-8 decoder.
REQ-011 The block SHALL have port sel_valid, output, 1 bit: sel is active and the decoder output is meaningful.
REQ-012 The block SHALL have port busy, output, 1 bit: high in SCAN.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a one-shot pass.
REQ-014 The block SHALL have port wrap, output, 1 bit: one-cycle pulse when a continuous scan returns to a lower or equal index.

Function
REQ-015 The block SHALL use states IDLE and SCAN; all outputs SHALL be registered.
REQ-016 IDLE with start=1, stop=0, en_mask!=0: the block SHALL capture en_mask, dwell and one_shot, then enter SCAN next cycle with sel = lowest set bit of the captured mask and sel_valid=1.
REQ-017 IDLE with start=1 and en_mask=0: the block SHALL stay in IDLE with no output change and no done pulse.
REQ-018 In SCAN, each sel value SHALL be held for exactly dwell+1 cycles; dwell=0 gives 1 cycle per channel.
REQ-019 On dwell expiry, sel SHALL move to the next set bit strictly above the current index, searching circularly modulo 8.
REQ-020 Continuous mode, if the next index is <= the current index: wrap SHALL pulse in the same cycle sel takes the new value.
REQ-021 One-shot mode, on expiry of the highest enabled channel: the block SHALL return to IDLE, drop sel_valid and busy, and pulse done in that same cycle.
REQ-022 In continuous mode with a single enabled channel, sel SHALL stay constant and wrap SHALL pulse every dwell+1 cycles.
REQ-023 en_mask, dwell and one_shot changes during SCAN SHALL be ignored until the next start.
REQ-024 start during SCAN SHALL be ignored.
REQ-025 stop=1 in SCAN: the block SHALL return to IDLE next cycle with sel_valid=0, busy=0 and no done or wrap pulse.
REQ-026 stop=1 together with start=1 in IDLE: the scan SHALL NOT start (stop wins).
REQ-027 In IDLE, sel SHALL hold its last value.

Reset
REQ-028 With rst_n low, the block SHALL be in IDLE with sel=0, sel_valid=0, busy=0, done=0, wrap=0, and the dwell counter and captured registers at 0.
REQ-029 Reset asserted mid-scan SHALL abort immediately with no done or wrap pulse.
REQ-030 The first start SHALL be honoured on the first clock edge after rst_n deasserts.

Structure
REQ-031 The shared package SHALL hold the state enum (IDLE, SCAN), NUM_CH=8 and SEL_W=3.
REQ-032 The combinational circular next-set-bit search SHALL be one sub-module, next_enabled_finder (inputs: mask, current index; outputs: next index, wrapped flag).

Verification
REQ-033 en_mask=8'b1010_0101, dwell=0, one_shot=1, start pulse -> sel 0,2,5,7, one cycle each; done pulses with sel_valid falling after sel=7.
REQ-034 en_mask=8'b1000_0001, dwell=2, one_shot=0 -> sel 0 for 3 cycles, then 7 for 3 cycles, then 0 with wrap=1; the pattern repeats.
REQ-035 en_mask=8'b0001_0000, continuous, dwell=1 -> sel=4 constant; wrap pulses every 2 cycles.
REQ-036 Start with en_mask=0 -> stays IDLE; sel_valid, busy and done stay 0.
REQ-037 Mid-scan en_mask change to 8'hFF, then stop -> the sequence follows the captured mask; the cycle after stop gives sel_valid=0 with no done.
REQ-038 rst_n pulled low during a dwell -> all outputs 0 immediately; no spurious done or wrap after release.
